// File: rtl/alu_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : alu_seq_pkg                                                 |
// | Desc   : Shared definitions for the ALU microsequencer: ALU opcode   |
// |          encodings, instruction word field positions and the        |
// |          sequencer state type.                                       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package alu_seq_pkg;

  // ALU opcodes; the sequencer forwards them unchanged.
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTS = 4'b0011;
  localparam logic [3:0] OP_XNOR = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;

  // Instruction word layout.
  localparam int unsigned WORD_W      = 24;
  localparam int unsigned OP_MSB      = 23;
  localparam int unsigned OP_LSB      = 20;
  localparam int unsigned HALT_BIT    = 19;
  localparam int unsigned USE_ACC_BIT = 18;
  localparam int unsigned RSVD_MSB    = 17;
  localparam int unsigned RSVD_LSB    = 16;
  localparam int unsigned A_MSB       = 15;
  localparam int unsigned A_LSB       = 8;
  localparam int unsigned B_MSB       = 7;
  localparam int unsigned B_LSB       = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_DONE   = 3'd4
  } alu_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : alu_seq_if                                                  |
// | Desc   : Bundle of control, ROM, ALU and result-stream signals of    |
// |          the ALU microsequencer.                                     |
// |          slave  : sequencer side (drives ROM address, ALU operands,  |
// |                   results and status).                               |
// |          master : environment side (start, ROM data, ALU result,     |
// |                   result ready).                                     |
// |          Macro ALU_SEQ_BACKPRESSURE_EN adds res_ready.               |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface alu_seq_if
  import alu_seq_pkg::*;
#(
  parameter int ADDR_W = 6
);
  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [WORD_W-1:0] rom_data;
  logic [7:0]        alu_n1;
  logic [7:0]        alu_n2;
  logic [3:0]        alu_op;
  logic [7:0]        alu_s1;
  logic              res_valid;
  logic [7:0]        res_data;
  logic [7:0]        acc;
  logic              busy;
  logic              done;
  logic              err;
`ifdef ALU_SEQ_BACKPRESSURE_EN
  logic              res_ready;
`endif

  modport slave (
    input  start,
    input  rom_data,
    input  alu_s1,
`ifdef ALU_SEQ_BACKPRESSURE_EN
    input  res_ready,
`endif
    output rom_addr,
    output alu_n1,
    output alu_n2,
    output alu_op,
    output res_valid,
    output res_data,
    output acc,
    output busy,
    output done,
    output err
  );

  modport master (
    output start,
    output rom_data,
    output alu_s1,
`ifdef ALU_SEQ_BACKPRESSURE_EN
    output res_ready,
`endif
    input  rom_addr,
    input  alu_n1,
    input  alu_n2,
    input  alu_op,
    input  res_valid,
    input  res_data,
    input  acc,
    input  busy,
    input  done,
    input  err
  );

endinterface
`default_nettype wire

// File: rtl/alu_seq_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : alu_seq_decode                                              |
// | Desc   : Combinational split of a 24-bit instruction word.          |
// |          i_word    : instruction word from the ROM                   |
// |          o_op      : ALU opcode                                      |
// |          o_halt    : last instruction of the program                 |
// |          o_use_acc : operand A comes from the accumulator            |
// |          o_a/o_b   : immediate operands                              |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  wire logic [WORD_W-1:0] i_word,
  output logic      [3:0]        o_op,
  output logic                   o_halt,
  output logic                   o_use_acc,
  output logic      [7:0]        o_a,
  output logic      [7:0]        o_b
);

  // Reserved bits carry no meaning; kept only so they are visibly ignored.
  logic [1:0] w_unused_rsvd;

  assign o_op          = i_word[OP_MSB:OP_LSB];
  assign o_halt        = i_word[HALT_BIT];
  assign o_use_acc     = i_word[USE_ACC_BIT];
  assign o_a           = i_word[A_MSB:A_LSB];
  assign o_b           = i_word[B_MSB:B_LSB];
  assign w_unused_rsvd = i_word[RSVD_MSB:RSVD_LSB];

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : alu_seq                                                     |
// | Desc   : Microsequencer that walks a program ROM from address 0 on   |
// |          start, presents each decoded instruction to an external    |
// |          combinational 8-bit ALU and captures the result into an    |
// |          accumulator and a result stream.                           |
// |          clk   : clock, rising edge                                  |
// |          rst_n : asynchronous active-low reset                       |
// |          bus   : alu_seq_if.slave (start/busy/done/err handshake,    |
// |                  ROM address/data, ALU operands/result, results)     |
// |          Macro ALU_SEQ_BACKPRESSURE_EN: results wait for res_ready.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int ADDR_W = 6
)
(
  input  wire logic   clk,
  input  wire logic   rst_n,
  alu_seq_if.slave    bus
);

  localparam logic [ADDR_W-1:0] C_PC_LAST = '1;

  alu_seq_state_t    r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [7:0]        r_alu_n1;
  logic [7:0]        r_alu_n2;
  logic [3:0]        r_alu_op;
  logic              r_halt;
  logic              r_res_valid;
  logic [7:0]        r_res_data;
  logic [7:0]        r_acc;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic [3:0]        w_op;
  logic              w_halt;
  logic              w_use_acc;
  logic [7:0]        w_a;
  logic [7:0]        w_b;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_capture;
  logic              w_fire;

  alu_seq_decode u_decode (
    .i_word    (bus.rom_data),
    .o_op      (w_op),
    .o_halt    (w_halt),
    .o_use_acc (w_use_acc),
    .o_a       (w_a),
    .o_b       (w_b)
  );

  assign w_pc_next = r_pc + 1'b1;

  // w_capture: the ALU result is written into acc/res_data.
  // w_fire:    the instruction retires and the sequencer moves on.
  // With backpressure, capture happens on the first EXEC cycle and
  // retirement waits for the res_valid/res_ready handshake.
  always_comb begin
`ifdef ALU_SEQ_BACKPRESSURE_EN
    w_capture = (r_state == ST_EXEC) && !r_res_valid;
    w_fire    = (r_state == ST_EXEC) && r_res_valid && bus.res_ready;
`else
    w_capture = (r_state == ST_EXEC);
    w_fire    = (r_state == ST_EXEC);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_rom_addr  <= '0;
      r_alu_n1    <= '0;
      r_alu_n2    <= '0;
      r_alu_op    <= '0;
      r_halt      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_acc       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
`ifndef ALU_SEQ_BACKPRESSURE_EN
      r_res_valid <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_pc       <= '0;
            r_rom_addr <= '0;
            r_err      <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_FETCH;
          end
        end

        // rom_addr was loaded on entry; the ROM word lands during this cycle.
        ST_FETCH: begin
          r_state <= ST_DECODE;
        end

        ST_DECODE: begin
          r_alu_op <= w_op;
          r_alu_n1 <= w_use_acc ? r_acc : w_a;
          r_alu_n2 <= w_b;
          r_halt   <= w_halt;
          r_state  <= ST_EXEC;
        end

        // alu_s1 has had a full cycle to settle from the registered operands.
        ST_EXEC: begin
          if (w_capture) begin
            r_acc       <= bus.alu_s1;
            r_res_data  <= bus.alu_s1;
            r_res_valid <= 1'b1;
          end
          if (w_fire) begin
`ifdef ALU_SEQ_BACKPRESSURE_EN
            r_res_valid <= 1'b0;
`endif
            if (r_halt) begin
              r_state <= ST_DONE;
            end else if (r_pc == C_PC_LAST) begin
              // Ran off the end of the ROM without a halt.
              r_err   <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_pc       <= w_pc_next;
              r_rom_addr <= w_pc_next;
              r_state    <= ST_FETCH;
            end
          end
        end

        ST_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rom_addr  = r_rom_addr;
  assign bus.alu_n1    = r_alu_n1;
  assign bus.alu_n2    = r_alu_n2;
  assign bus.alu_op    = r_alu_op;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.acc       = r_acc;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule
`default_nettype wire
